ul_srch_90k_seq: RTL
====================

UL_SRCH_90K_SEQ -- requirements
Module: ul_srch_90k_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: run request; sampled only in IDLE.
REQ-004 SHALL have port scs, input, 2 bits: subcarrier spacing code, sampled with start; 1 selects gap 18, 2 selects gap 6, 3 selects gap 3, 0 is invalid.
REQ-005 SHALL have port re_num, input, 8 bits: number of REs to walk, sampled with start.
REQ-006 SHALL have port abort, input, 1 bit: terminates a run immediately.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-008 SHALL have port out_vld, output, 1 bit: the output beat is valid.
REQ-009 SHALL have port re_index, output, 8 bits: current RE index.
REQ-010 SHALL have port srch_seg, output, 4 bits: segment equal to floor(re_index/gap).
REQ-011 SHALL have port srch_mod, output, 5 bits: offset equal to re_index mod gap.
REQ-012 SHALL have port last, output, 1 bit: the beat is the final RE of the run.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last beat is accepted.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE, on start with valid config, latch scs and re_num, clear re_index, srch_seg and srch_mod, and enter RUN on the next cycle.
REQ-018 SHALL treat config as valid only when scs!=0 and 1<=re_num<=10*gap (180, 60 or 30).
REQ-019 SHALL, on start with invalid config, pulse cfg_err on the next cycle and remain in IDLE with no beats.
REQ-020 SHALL drive out_vld=1 throughout RUN; a beat is accepted when out_vld and out_ready are both high.
REQ-021 SHALL hold re_index, srch_seg, srch_mod and last stable while out_vld=1 and out_ready=0.
REQ-022 SHALL, on an accepted non-last beat, increment re_index; if srch_mod==gap-1, set srch_mod=0 and increment srch_seg, otherwise increment srch_mod.
REQ-023 SHALL compute srch_seg and srch_mod with incremental counters only; no divider and no comparator chain.
REQ-024 SHALL drive last=1 exactly when re_index==re_num-1 in RUN.
REQ-025 SHALL, on an accepted last beat, enter DONE; in DONE, done=1 and out_vld=0, and the FSM returns to IDLE on the next cycle.
REQ-026 SHALL ignore start outside IDLE, with no cfg_err.
REQ-027 SHALL, on abort in RUN or DONE, return to IDLE on the next cycle with no done pulse; abort overrides a beat accepted in the same cycle.
REQ-028 SHALL ignore abort in IDLE; abort and start in the same IDLE cycle SHALL start the run.
REQ-029 SHALL register all outputs with zero combinational paths from inputs to outputs; first beat 1 cycle after start; one beat per cycle when out_ready is held high.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, force state to IDLE; out_vld, last, busy, done and cfg_err to 0; re_index, srch_seg and srch_mod to 0; latched scs and re_num to 0.
REQ-031 SHALL let reset mid-run discard the run with no done pulse.

Structure
REQ-032 SHALL place in shared package ul_srch_pkg: SCS code constants, gap constants 18/6/3, segment count 10, and the FSM state enum.
REQ-033 SHALL use one sub-module, ul_srch_90k_cnt, as the seg/mod wrap counter with ports clr, inc, gap and seg/mod outputs.

Verification
REQ-034 SHALL cover: scs=3, re_num=30, out_ready=1 -> 30 consecutive beats, seg/mod (0,0),(0,1),(0,2),(1,0)...(9,2); last on re_index 29; done one cycle later.
REQ-035 SHALL cover: scs=1, re_num=180 with random out_ready -> every beat matches floor(i/18) and i mod 18; outputs stable while stalled; exactly 180 beats.
REQ-036 SHALL cover: scs=0, or scs=2 with re_num=61, or re_num=0 -> cfg_err pulse, out_vld stays 0, busy stays 0.
REQ-037 SHALL cover: scs=2, re_num=1 -> single beat with seg=0, mod=0, last=1, then done.
REQ-038 SHALL cover: abort asserted at re_index 7 while a beat is accepted -> IDLE next cycle, no done, a following start is accepted normally.
REQ-039 SHALL cover: rst_n=0 mid-run, and start issued during RUN -> all outputs zero after reset; start ignored during RUN.

Source files
------------

// File: rtl/ul_srch_pkg.sv
// Shared constants and types for the uplink search RE sequencer: SCS codes,
// per-SCS segment gap, and the sequencer FSM states.
package ul_srch_pkg;

    localparam logic [1:0] SCS_INV = 2'd0;
    localparam logic [1:0] SCS_18  = 2'd1;
    localparam logic [1:0] SCS_6   = 2'd2;
    localparam logic [1:0] SCS_3   = 2'd3;

    localparam logic [4:0] GAP_18 = 5'd18;
    localparam logic [4:0] GAP_6  = 5'd6;
    localparam logic [4:0] GAP_3  = 5'd3;

    localparam int SEG_NUM = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [4:0] gap_of(input logic [1:0] scs);
        logic [4:0] gap;
        case (scs)
            SCS_18:  gap = GAP_18;
            SCS_6:   gap = GAP_6;
            SCS_3:   gap = GAP_3;
            default: gap = 5'd0;
        endcase
        return gap;
    endfunction

    // Largest legal run length: one full set of segments at the selected gap.
    function automatic logic [7:0] max_re(input logic [1:0] scs);
        return 8'(SEG_NUM * int'(gap_of(scs)));
    endfunction

endpackage

// File: rtl/ul_srch_90k_cnt.sv
// Segment/offset wrap counter: offset counts 0..gap-1, segment steps on each wrap.
module ul_srch_90k_cnt
    import ul_srch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [4:0] gap,
    output logic [3:0] seg,
    output logic [4:0] mod
);

    logic [3:0] seg_reg;
    logic [4:0] mod_reg;
    logic       wrap;

    assign wrap = (mod_reg == gap - 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_reg <= 4'd0;
            mod_reg <= 5'd0;
        end else if (clr) begin
            seg_reg <= 4'd0;
            mod_reg <= 5'd0;
        end else if (inc) begin
            if (wrap) begin
                mod_reg <= 5'd0;
                seg_reg <= seg_reg + 4'd1;
            end else begin
                mod_reg <= mod_reg + 5'd1;
            end
        end
    end

    assign seg = seg_reg;
    assign mod = mod_reg;

endmodule

// File: rtl/ul_srch_90k_seq.sv
// Uplink search RE sequencer: walks re_num REs, emitting index plus segment/offset
// per beat under valid/ready flow control.
module ul_srch_90k_seq
    import ul_srch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] scs,
    input  logic [7:0] re_num,
    input  logic       abort,
    input  logic       out_ready,
    output logic       out_vld,
    output logic [7:0] re_index,
    output logic [3:0] srch_seg,
    output logic [4:0] srch_mod,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    state_t     state_reg, state_next;
    logic [1:0] scs_reg;
    logic [7:0] re_num_reg;
    logic [7:0] re_index_reg, re_index_next;
    logic       last_reg, last_next;
    logic       cfg_err_reg, cfg_err_next;

    logic cfg_ok;
    logic load;
    logic beat_acc;
    logic advance;

    assign cfg_ok   = (scs != SCS_INV) && (re_num != 8'd0) && (re_num <= max_re(scs));
    assign load     = (state_reg == ST_IDLE) && start && cfg_ok;
    assign beat_acc = (state_reg == ST_RUN) && out_ready;
    // Abort wins over a beat accepted in the same cycle.
    assign advance  = beat_acc && !last_reg && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            scs_reg      <= 2'd0;
            re_num_reg   <= 8'd0;
            re_index_reg <= 8'd0;
            last_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            re_index_reg <= re_index_next;
            last_reg     <= last_next;
            cfg_err_reg  <= cfg_err_next;
            if (load) begin
                scs_reg    <= scs;
                re_num_reg <= re_num;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (load) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (beat_acc && last_reg)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // last is precomputed one beat ahead so it stays a plain register.
    always_comb begin
        re_index_next = re_index_reg;
        last_next     = last_reg;
        cfg_err_next  = (state_reg == ST_IDLE) && start && !cfg_ok;
        if (load) begin
            re_index_next = 8'd0;
            last_next     = (re_num == 8'd1);
        end else if (state_next != ST_RUN) begin
            last_next = 1'b0;
        end else if (advance) begin
            re_index_next = re_index_reg + 8'd1;
            last_next     = (re_index_reg + 8'd1 == re_num_reg - 8'd1);
        end
    end

    ul_srch_90k_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (advance),
        .gap   (gap_of(scs_reg)),
        .seg   (srch_seg),
        .mod   (srch_mod)
    );

    assign out_vld  = (state_reg == ST_RUN);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign re_index = re_index_reg;
    assign last     = last_reg;
    assign cfg_err  = cfg_err_reg;

endmodule
